fp_unit_arbiter: RTL and testbench

//  Round-robin scheduler sharing one pipelined FP arithmetic unit among 4 requesters.

---
 rtl/fp_arb_pkg.sv | 23 ++
 rtl/rr_pick4.sv | 24 ++
 rtl/fp_unit_arbiter.sv | 89 ++++++++
 tb/tb_fp_unit_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// Shared types and helpers for the FP unit round-robin arbiter.
package fp_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] sel;
  } tag_t;

  function automatic logic [SEL_W-1:0] onehot2bin(input logic [NUM_REQ-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

  function automatic logic [NUM_REQ-1:0] bin2onehot(input logic [SEL_W-1:0] bin);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[bin] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotate-priority picker: first set request at or after iPtr, wrapping 3->0.
module rr_pick4
  import fp_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] iReq,
  input  logic [SEL_W-1:0]   iPtr,
  output logic [SEL_W-1:0]   oWin,
  output logic               oFound
);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [NUM_REQ-1:0]   firstSet;

  // Rotate so the pointer sits at bit 0, isolate the lowest set bit, then rotate the index back.
  always_comb begin
    doubled  = {iReq, iReq} >> iPtr;
    rotated  = doubled[NUM_REQ-1:0];
    firstSet = rotated & (~rotated + 4'd1);
    oWin     = onehot2bin(firstSet) + iPtr;
    oFound   = |iReq;
  end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Round-robin issue scheduler for a shared pipelined FP unit, with a tag pipe
// that tracks each issued operation and strobes its owner when the result emerges.
module fp_unit_arbiter
  import fp_arb_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic               iClk,
  input  logic               iReset_n,
  input  logic [NUM_REQ-1:0] iReq,
  input  logic               iStall,
  output logic [NUM_REQ-1:0] oGnt,
  output logic [SEL_W-1:0]   oSel,
  output logic               oIssue,
  output logic [NUM_REQ-1:0] oDone,
  output logic [SEL_W-1:0]   oDoneSel,
  output logic               oBusy
);

  logic [SEL_W-1:0]   rPtr;
  logic [SEL_W-1:0]   lastSel;
  logic [SEL_W-1:0]   win;
  logic               found;
  logic [LATENCY-1:0] validVec;
  tag_t               lastTag;

  rr_pick4 uPick (
    .iReq   (iReq),
    .iPtr   (rPtr),
    .oWin   (win),
    .oFound (found)
  );

  // Grant is gated by reset so a held request cannot leak through while the block is cleared.
  always_comb begin
    oGnt   = '0;
    oIssue = 1'b0;
    oSel   = lastSel;
    if (iReset_n && found && !iStall) begin
      oGnt   = bin2onehot(win);
      oIssue = 1'b1;
      oSel   = win;
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      rPtr    <= '0;
      lastSel <= '0;
    end else if (oIssue) begin
      rPtr    <= win + 2'd1;
      lastSel <= win;
    end
  end

  for (genvar i = 0; i < LATENCY; i++) begin : gStage
    tag_t stage;
    tag_t prev;

    if (i == 0) begin : gHead
      assign prev = '{valid: oIssue, sel: oSel};
    end else begin : gBody
      assign prev = gStage[i-1].stage;
    end

    // A stall freezes every stage together so entries stay aligned with the FP unit.
    always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
        stage <= '0;
      end else if (!iStall) begin
        stage <= prev;
      end
    end

    assign validVec[i] = stage.valid;
  end

  assign lastTag = gStage[LATENCY-1].stage;

  always_comb begin
    oDone    = '0;
    oDoneSel = lastTag.sel;
    oBusy    = |validVec;
    if (lastTag.valid && !iStall) begin
      oDone = bin2onehot(lastTag.sel);
    end
  end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed self-checking bench for fp_unit_arbiter with LATENCY=3.
module tb_fp_unit_arbiter;

  logic       iClk;
  logic       iReset_n;
  logic [3:0] iReq;
  logic       iStall;
  logic [3:0] oGnt;
  logic [1:0] oSel;
  logic       oIssue;
  logic [3:0] oDone;
  logic [1:0] oDoneSel;
  logic       oBusy;

  int checkCount = 0;
  int errorCount = 0;

  logic [3:0] sbQ[$];
  logic [3:0] gntTab[6] = '{4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [3:0] expG;
  logic [3:0] expD;

  fp_unit_arbiter #(.LATENCY(3)) dut (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .iReq     (iReq),
    .iStall   (iStall),
    .oGnt     (oGnt),
    .oSel     (oSel),
    .oIssue   (oIssue),
    .oDone    (oDone),
    .oDoneSel (oDoneSel),
    .oBusy    (oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // New inputs land on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic [3:0] req, input logic stall);
    @(negedge iClk);
    iReq   = req;
    iStall = stall;
    #1;
  endtask

  initial begin
    iReset_n = 1'b0;
    iReq     = 4'hF;
    iStall   = 1'b0;

    repeat (3) @(negedge iClk);
    #1;
    checkOutput("rstGnt",   {4'd0, oGnt},   8'h00);
    checkOutput("rstIssue", {7'd0, oIssue}, 8'h00);
    checkOutput("rstDone",  {4'd0, oDone},  8'h00);
    checkOutput("rstBusy",  {7'd0, oBusy},  8'h00);
    checkOutput("rstSel",   {6'd0, oSel},   8'h00);

    @(negedge iClk);
    iReset_n = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) applyStimulus((c < 8) ? 4'hF : 4'h0, 1'b0);
      expG = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
      expD = (c >= 3 && c <= 10) ? 4'(1 << ((c - 3) % 4)) : 4'h0;
      checkOutput("rrGnt",  {4'd0, oGnt},  {4'd0, expG});
      checkOutput("rrDone", {4'd0, oDone}, {4'd0, expD});
      checkOutput("rrBusy", {7'd0, oBusy}, (c >= 1 && c <= 10) ? 8'h01 : 8'h00);
    end

    applyStimulus(4'b0010, 1'b0);
    checkOutput("skipA", {4'd0, oGnt}, 8'h02);
    applyStimulus(4'b0011, 1'b0);
    checkOutput("skipB", {4'd0, oGnt}, 8'h01);
    applyStimulus(4'b0011, 1'b0);
    checkOutput("skipC", {4'd0, oGnt}, 8'h02);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("wrapA", {4'd0, oGnt}, 8'h08);
    checkOutput("wrapSelA", {6'd0, oSel}, 8'h03);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("idleGnt",   {4'd0, oGnt},   8'h00);
    checkOutput("idleIssue", {7'd0, oIssue}, 8'h00);
    checkOutput("idleSel",   {6'd0, oSel},   8'h03);
    applyStimulus(4'b1001, 1'b0);
    checkOutput("wrapB", {4'd0, oGnt}, 8'h01);
    repeat (4) applyStimulus(4'b0000, 1'b0);
    checkOutput("drainBusy", {7'd0, oBusy}, 8'h00);

    applyStimulus(4'b0010, 1'b0);
    checkOutput("stN",       {4'd0, oGnt},   8'h02);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("stN1Gnt",   {4'd0, oGnt},   8'h00);
    checkOutput("stN1Issue", {7'd0, oIssue}, 8'h00);
    checkOutput("stN1Sel",   {6'd0, oSel},   8'h01);
    checkOutput("stN1Busy",  {7'd0, oBusy},  8'h01);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("stN2Gnt",   {4'd0, oGnt},   8'h00);
    checkOutput("stN2Done",  {4'd0, oDone},  8'h00);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("stN3Gnt",   {4'd0, oGnt},   8'h04);
    checkOutput("stN3Done",  {4'd0, oDone},  8'h00);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("stN4Done",  {4'd0, oDone},  8'h00);
    checkOutput("stN4Sel",   {6'd0, oSel},   8'h02);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("stN5Done",  {4'd0, oDone},  8'h02);
    checkOutput("stN5DSel",  {6'd0, oDoneSel}, 8'h01);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("stN6Done",  {4'd0, oDone},  8'h00);
    checkOutput("stN6Busy",  {7'd0, oBusy},  8'h01);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("stN7Done",  {4'd0, oDone},  8'h04);
    checkOutput("stN7DSel",  {6'd0, oDoneSel}, 8'h02);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("stN8Done",  {4'd0, oDone},  8'h00);
    checkOutput("stN8Busy",  {7'd0, oBusy},  8'h00);

    for (int c = 0; c < 10; c++) begin
      applyStimulus((c < 6) ? 4'hF : 4'h0, 1'b0);
      expG = (c < 6) ? gntTab[c] : 4'h0;
      checkOutput("b2bGnt", {4'd0, oGnt}, {4'd0, expG});
      if (c < 6) sbQ.push_back(expG);
      expD = (c >= 3 && c < 9 && sbQ.size() > 0) ? sbQ.pop_front() : 4'h0;
      checkOutput("b2bDone", {4'd0, oDone}, {4'd0, expD});
      if (c >= 8) checkOutput("b2bBusy", {7'd0, oBusy}, (c == 8) ? 8'h01 : 8'h00);
    end

    applyStimulus(4'b0110, 1'b0);
    checkOutput("mfA", {4'd0, oGnt}, 8'h02);
    applyStimulus(4'b0110, 1'b0);
    checkOutput("mfB", {4'd0, oGnt}, 8'h04);
    applyStimulus(4'b0011, 1'b0);
    checkOutput("mfC", {4'd0, oGnt}, 8'h01);

    @(negedge iClk);
    iReset_n = 1'b0;
    iReq     = 4'hF;
    #1;
    checkOutput("mfRstGnt",  {4'd0, oGnt},  8'h00);
    checkOutput("mfRstDone", {4'd0, oDone}, 8'h00);
    checkOutput("mfRstBusy", {7'd0, oBusy}, 8'h00);
    @(negedge iClk);
    iReset_n = 1'b1;
    iReq     = 4'h0;
    #1;
    checkOutput("mfRelBusy", {7'd0, oBusy}, 8'h00);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'h0, 1'b0);
      checkOutput("mfNoDone", {4'd0, oDone}, 8'h00);
    end
    applyStimulus(4'hF, 1'b0);
    checkOutput("mfPtr", {4'd0, oGnt}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
